// File: rtl/bist_sequencer_pkg.sv
// State encoding and shared defaults for the BIST sequencer.
package bist_sequencer_pkg;

  localparam int NCLOCK_DEFAULT = 650;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_INIT    = 3'd2,
    ST_RUNNING = 3'd3,
    ST_FINISH  = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/bist_run_counter.sv
// Per-round running-cycle counter with clear, enable and terminal-count flag.
// Latency: count and flag update one cycle after enable; clear wins over enable.
module bist_run_counter #(
  parameter  int NCLOCK = 650,
  localparam int CNT_W  = $clog2(NCLOCK + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc = (cnt == CNT_W'(NCLOCK - 1));

endmodule

// File: rtl/bist_sequencer.sv
// Multi-round BIST sequencer: START, INIT, NCLOCK running cycles, FINISH per round, then DONE.
// Moore outputs from the state register; abort returns to IDLE next cycle; optional signature check under BIST_SIG_CHECK_EN.
module bist_sequencer
  import bist_sequencer_pkg::*;
#(
  parameter  int               NCLOCK  = NCLOCK_DEFAULT,
  parameter  int               NROUNDS = 1,
  parameter  int               SIG_W   = 16,
  parameter  logic [SIG_W-1:0] GOLDEN  = '0,
  localparam int               CNT_W   = $clog2(NCLOCK + 1),
  localparam int               RND_W   = $clog2(NROUNDS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [SIG_W-1:0] sig_in,
  output logic             init,
  output logic             running,
  output logic             toggle,
  output logic             finish,
  output logic             busy,
  output logic [RND_W-1:0] round_idx,
  output logic             bist_end,
  output logic             aborted,
  output logic             pass,
  output logic             fail
);

  state_t           state_q, state_d;
  logic             start_q;
  logic             rise;
  logic             abort_take;
  logic             last_round;
  logic [RND_W-1:0] rnd;
  logic [CNT_W-1:0] cnt;
  logic             cnt_tc;
  logic             cnt_en;
  logic             cnt_clr;
  logic             unused;

  // start_q resets high so a start held across reset never looks like an edge
  assign rise       = start & ~start_q;
  assign abort_take = abort & (state_q != ST_IDLE);
  assign last_round = (rnd == RND_W'(NROUNDS - 1));

  assign cnt_en  = (state_q == ST_RUNNING) & ~cnt_tc;
  assign cnt_clr = (state_q == ST_FINISH) | abort_take;

  bist_run_counter #(.NCLOCK(NCLOCK)) u_run_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .cnt   (cnt),
    .tc    (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      start_q <= 1'b1;
      aborted <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start;
      aborted <= abort_take;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (rise && !abort) state_d = ST_START;
      ST_START:   state_d = ST_INIT;
      ST_INIT:    state_d = ST_RUNNING;
      ST_RUNNING: if (cnt_tc) state_d = ST_FINISH;
      ST_FINISH:  state_d = last_round ? ST_DONE : ST_INIT;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (abort_take) state_d = ST_IDLE;
  end

  // round index stays at the last round through DONE, then returns to 0
  always_ff @(posedge clk) begin
    if (reset || abort_take) begin
      rnd <= '0;
    end else if (state_q == ST_START || state_q == ST_DONE) begin
      rnd <= '0;
    end else if (state_q == ST_FINISH && !last_round) begin
      rnd <= rnd + RND_W'(1);
    end
  end

  assign init      = (state_q == ST_INIT);
  assign running   = (state_q == ST_RUNNING);
  assign finish    = (state_q == ST_FINISH);
  assign bist_end  = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign toggle    = running & cnt[0] & ~cnt_tc;
  assign round_idx = rnd;

`ifdef BIST_SIG_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      pass <= 1'b0;
      fail <= 1'b0;
    end else if (!abort_take) begin
      if (state_q == ST_START) begin
        pass <= 1'b0;
        fail <= 1'b0;
      end else if (state_q == ST_FINISH && last_round) begin
        pass <= (sig_in == GOLDEN);
        fail <= (sig_in != GOLDEN);
      end
    end
  end
  assign unused = ^cnt[CNT_W-1:1];
`else
  assign pass   = 1'b0;
  assign fail   = 1'b0;
  assign unused = ^{cnt[CNT_W-1:1], sig_in};
`endif

endmodule

// File: tb/tb_bist_sequencer.sv
// Bench for bist_sequencer: single-round and three-round instances driven in parallel, checked against a cycle-offset model.
module tb_bist_sequencer;

  localparam int          NC   = 10;
  localparam logic [15:0] GOLD = 16'hBEEF;

  typedef struct packed {
    logic       init;
    logic       running;
    logic       toggle;
    logic       finish;
    logic       busy;
    logic       bist_end;
    logic [1:0] rnd;
  } outs_t;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [15:0] sig_in;

  logic init_o[2], run_o[2], tog_o[2], fin_o[2], busy_o[2], end_o[2];
  logic abd_o[2], pass_o[2], fail_o[2];
  logic [0:0] r1;
  logic [1:0] r3;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int base = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  bist_sequencer #(.NCLOCK(NC), .NROUNDS(1), .SIG_W(16), .GOLDEN(GOLD)) dut1 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .sig_in(sig_in),
    .init(init_o[0]), .running(run_o[0]), .toggle(tog_o[0]), .finish(fin_o[0]),
    .busy(busy_o[0]), .round_idx(r1), .bist_end(end_o[0]), .aborted(abd_o[0]),
    .pass(pass_o[0]), .fail(fail_o[0])
  );

  bist_sequencer #(.NCLOCK(NC), .NROUNDS(3), .SIG_W(16), .GOLDEN(GOLD)) dut3 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .sig_in(sig_in),
    .init(init_o[1]), .running(run_o[1]), .toggle(tog_o[1]), .finish(fin_o[1]),
    .busy(busy_o[1]), .round_idx(r3), .bist_end(end_o[1]), .aborted(abd_o[1]),
    .pass(pass_o[1]), .fail(fail_o[1])
  );

  function automatic int rounds_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // Expected outputs from the offset t since the accepted start edge (t=1 is START).
  function automatic outs_t expect_outs(input int rounds, input bit b, input int t);
    outs_t o;
    int u, r, p;
    o = '0;
    if (b) begin
      o.busy = 1'b1;
      if (t >= 2) begin
        u = t - 2;
        r = u / (NC + 2);
        p = u % (NC + 2);
        if (r < rounds) begin
          o.rnd     = r[1:0];
          o.init    = (p == 0);
          o.running = (p >= 1 && p <= NC);
          o.finish  = (p == NC + 1);
          o.toggle  = o.running && ((p - 1) % 2 == 1) && (p - 1 != NC - 1);
        end else begin
          o.bist_end = 1'b1;
          o.rnd      = 2'(rounds - 1);
        end
      end
    end
    return o;
  endfunction

  bit m_busy[2], m_abd[2], m_pass[2], m_fail[2];
  int m_t[2];
  bit m_sq = 1'b1;

  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      int done_t;
      done_t = 2 + rounds_of(k) * (NC + 2);
      if (reset) begin
        m_busy[k] = 0; m_t[k] = 0; m_abd[k] = 0; m_pass[k] = 0; m_fail[k] = 0;
      end else begin
        m_abd[k] = m_busy[k] && abort;
        if (m_busy[k] && abort) begin
          m_busy[k] = 0;
        end else if (m_busy[k]) begin
`ifdef BIST_SIG_CHECK_EN
          if (m_t[k] == 1) begin m_pass[k] = 0; m_fail[k] = 0; end
          if (m_t[k] == done_t - 1) begin
            m_pass[k] = (sig_in == GOLD);
            m_fail[k] = (sig_in != GOLD);
          end
`endif
          m_t[k]++;
          if (m_t[k] > done_t) m_busy[k] = 0;
        end else if (start && !m_sq && !abort) begin
          m_busy[k] = 1;
          m_t[k]    = 1;
        end
      end
    end
    m_sq = reset ? 1'b1 : start;
  end

  int n_init[2], n_run[2], n_end[2], n_busy[2], n_abd[2], f_init[2], f_fin[2], e_end[2], max_rnd[2];
  logic [9:0] tog_bits;

  task automatic clear_stats();
    for (int k = 0; k < 2; k++) begin
      n_init[k] = 0; n_run[k] = 0; n_end[k] = 0; n_busy[k] = 0; n_abd[k] = 0;
      f_init[k] = -1; f_fin[k] = -1; e_end[k] = -1; max_rnd[k] = 0;
    end
    tog_bits = '0;
    base = cyc;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        outs_t e, a;
        int rel;
        e = expect_outs(rounds_of(k), m_busy[k], m_t[k]);
        a = {init_o[k], run_o[k], tog_o[k], fin_o[k], busy_o[k], end_o[k],
             (k == 0) ? {1'b0, r1} : r3};
        chk($sformatf("cycle_dut%0d_t%0d", k, cyc - base),
            int'({a, abd_o[k], pass_o[k], fail_o[k]}),
            int'({e, m_abd[k], m_pass[k], m_fail[k]}));
        rel = cyc - base;
        if (a.init) begin n_init[k]++; if (f_init[k] < 0) f_init[k] = rel; end
        if (a.running) n_run[k]++;
        if (k == 0 && a.running) tog_bits = {tog_bits[8:0], a.toggle};
        if (a.finish && f_fin[k] < 0) f_fin[k] = rel;
        if (a.bist_end) begin n_end[k]++; e_end[k] = rel; end
        if (a.busy) n_busy[k]++;
        if (abd_o[k]) n_abd[k]++;
        if (int'(a.rnd) > max_rnd[k]) max_rnd[k] = int'(a.rnd);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; abort = 1'b0; sig_in = GOLD;
    clear_stats();
    tick(3);
    chk("reset_state_dut3", int'({init_o[1], run_o[1], tog_o[1], fin_o[1], busy_o[1],
        end_o[1], abd_o[1], pass_o[1], fail_o[1], r3}), 0);
    chk_en = 1'b1;
    tick(1);

    // start held high across reset release
    reset = 1'b0;
    clear_stats();
    tick(20);
    chk("held_start_no_run", n_busy[0] + n_busy[1], 0);

    // single and triple round runs from one start edge
    start = 1'b0;
    tick(3);
    clear_stats();
    start = 1'b1;
    tick(5);
    start = 1'b0;
    tick(40);
    chk("r1_first_init", f_init[0], 2);
    chk("r1_first_finish", f_fin[0], 13);
    chk("r1_bist_end_cycle", e_end[0], 14);
    chk("r1_bist_end_count", n_end[0], 1);
    chk("r1_running_cycles", n_run[0], 10);
    chk("r1_toggle_seq", int'(tog_bits), 340);
    chk("r1_max_round", max_rnd[0], 0);
    chk("r3_init_count", n_init[1], 3);
    chk("r3_running_cycles", n_run[1], 30);
    chk("r3_bist_end_cycle", e_end[1], 38);
    chk("r3_bist_end_count", n_end[1], 1);
    chk("r3_max_round", max_rnd[1], 2);
`ifdef BIST_SIG_CHECK_EN
    chk("pass_after_golden", int'({pass_o[0], fail_o[0], pass_o[1], fail_o[1]}), 4'b1010);
`else
    chk("pass_fail_tied_low", int'({pass_o[0], fail_o[0], pass_o[1], fail_o[1]}), 0);
`endif

    // abort on the 5th running cycle
    clear_stats();
    start = 1'b1;
    tick(7);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    tick(5);
    chk("abort_pulse_r1", n_abd[0], 1);
    chk("abort_pulse_r3", n_abd[1], 1);
    chk("abort_no_end", n_end[0] + n_end[1], 0);
    chk("abort_running_cycles", n_run[0], 5);
    chk("abort_busy_cycles", n_busy[1], 7);

    // fresh start after abort, with a start re-pulse mid-run
    start = 1'b0;
    tick(2);
    clear_stats();
    start = 1'b1;
    tick(5);
    start = 1'b0;
    tick(1);
    start = 1'b1;
    tick(2);
    start = 1'b0;
    tick(37);
    chk("rerun_end_r1", e_end[0], 14);
    chk("rerun_end_r3", e_end[1], 38);
    chk("rerun_init_r3", n_init[1], 3);
    chk("rerun_end_count", n_end[0] + n_end[1], 2);

    // abort together with a start edge while idle
    clear_stats();
    abort = 1'b1;
    start = 1'b1;
    tick(1);
    abort = 1'b0;
    tick(10);
    chk("abort_start_idle", n_busy[0] + n_busy[1], 0);
    chk("abort_idle_no_pulse", n_abd[0] + n_abd[1], 0);
    start = 1'b0;

    // mismatching signature
    sig_in = 16'h1234;
    tick(2);
    clear_stats();
    start = 1'b1;
    tick(45);
    start = 1'b0;
    tick(2);
    chk("bad_sig_end_count", n_end[0] + n_end[1], 2);
`ifdef BIST_SIG_CHECK_EN
    chk("fail_after_bad_sig", int'({pass_o[0], fail_o[0], pass_o[1], fail_o[1]}), 4'b0101);
`else
    chk("pass_fail_still_low", int'({pass_o[0], fail_o[0], pass_o[1], fail_o[1]}), 0);
`endif

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
